// File: rtl/cache_mem_responder_pkg.sv
// Shared cache<->memory protocol types plus the memory responder's state, line type and defaults.
package cache_parameters;

  localparam int WORD_WIDTH = 32;
  localparam int BLOCK_SIZE = 4;
  localparam int ADDR_WIDTH = 32;
  // Byte address: word offset plus byte-in-word offset sit below the line index.
  localparam int LINE_LSB   = $clog2(BLOCK_SIZE) + $clog2(WORD_WIDTH / 8);
  localparam int TAG_MSB    = ADDR_WIDTH - 1;

  localparam int MEM_LINES_DEFAULT   = 1024;
  localparam int MEM_LATENCY_DEFAULT = 4;

  typedef logic [BLOCK_SIZE-1:0][WORD_WIDTH-1:0] line_t;

  typedef struct packed {
    logic                  cs;
    logic                  rw;
    logic [ADDR_WIDTH-1:0] addr;
    line_t                 data;
  } memory_request_t;

  typedef struct packed {
    logic  ack;
    line_t data;
  } memory_response_t;

  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} memresp_state_t;

endpackage

// File: rtl/cache_mem_responder_line_ram.sv
// Single-port line-wide storage with a registered, enable-gated read port.
module memresp_line_ram
  import cache_parameters::*;
#(
  parameter int LINES = MEM_LINES_DEFAULT,
  parameter int IDX_W = $clog2(LINES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             re,
  input  logic             rclr,
  input  logic [IDX_W-1:0] idx,
  input  line_t            wdata,
  output line_t            rdata
);

  line_t mem [LINES];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  // rdata is the response data register: it only moves on a read response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rdata <= '0;
    else if (rclr) rdata <= '0;
    else if (re)   rdata <= mem[idx];
  end

endmodule

// File: rtl/cache_mem_responder.sv
// Backing memory for the cache line protocol: fixed-latency line read/write with one-cycle ack.
// Optional MEMRESP_OOR_ERR_EN adds an err output and out-of-range index detection.
module cache_mem_responder
  import cache_parameters::*;
#(
  parameter int MEM_LINES = MEM_LINES_DEFAULT,
  parameter int LATENCY   = MEM_LATENCY_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  memory_request_t  mem_req,
  output memory_response_t mem_res,
`ifdef MEMRESP_OOR_ERR_EN
  output logic             err,
`endif
  output logic             busy
);

  localparam int IDX_W  = $clog2(MEM_LINES);
  localparam int CNT_W  = $clog2(LATENCY + 1);
  localparam int FULL_W = TAG_MSB - LINE_LSB + 1;

  memresp_state_t   state;
  logic [CNT_W-1:0] cnt;
  logic             req_rw;
  logic             req_oor;
  logic [IDX_W-1:0] req_idx;
  line_t            req_data;
  logic             ack_q;
  logic             busy_q;

  logic [FULL_W-1:0] in_full_idx;
  logic [IDX_W-1:0]  in_idx;
  logic              in_oor;
  logic              accept, enter_resp, cur_rw, cur_oor;
  logic              ram_we, ram_re, ram_rclr;
  logic [IDX_W-1:0]  ram_idx;
  line_t             ram_rdata;
  logic              unused_bits;

  assign in_full_idx = mem_req.addr[TAG_MSB:LINE_LSB];
  assign in_idx      = in_full_idx[IDX_W-1:0];
  assign unused_bits = ^{mem_req.addr[LINE_LSB-1:0], in_full_idx};

`ifdef MEMRESP_OOR_ERR_EN
  assign in_oor = (in_full_idx >= FULL_W'(MEM_LINES));
`else
  assign in_oor = 1'b0;
`endif

  // With LATENCY=1 the read happens on the acceptance edge, so use the live request.
  assign accept     = (state == IDLE) && mem_req.cs;
  assign enter_resp = (accept && (LATENCY == 1)) || ((state == WAIT) && (cnt == '0));
  assign cur_rw     = (state == IDLE) ? mem_req.rw : req_rw;
  assign cur_oor    = (state == IDLE) ? in_oor     : req_oor;

  assign ram_we   = (state == RESPOND) && req_rw && !req_oor;
  assign ram_re   = enter_resp && !cur_rw && !cur_oor;
  assign ram_rclr = enter_resp && !cur_rw && cur_oor;
  assign ram_idx  = (state == IDLE) ? in_idx : req_idx;

  memresp_line_ram #(.LINES(MEM_LINES), .IDX_W(IDX_W)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .re    (ram_re),
    .rclr  (ram_rclr),
    .idx   (ram_idx),
    .wdata (req_data),
    .rdata (ram_rdata)
  );

`ifdef MEMRESP_OOR_ERR_EN
  logic err_q;
  assign err = err_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      req_rw   <= 1'b0;
      req_oor  <= 1'b0;
      req_idx  <= '0;
      req_data <= '0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
`ifdef MEMRESP_OOR_ERR_EN
      err_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (mem_req.cs) begin
            req_rw   <= mem_req.rw;
            req_oor  <= in_oor;
            req_idx  <= in_idx;
            req_data <= mem_req.data;
            busy_q   <= 1'b1;
            if (LATENCY == 1) begin
              state <= RESPOND;
              ack_q <= 1'b1;
`ifdef MEMRESP_OOR_ERR_EN
              err_q <= in_oor;
`endif
            end else begin
              state <= WAIT;
              cnt   <= CNT_W'(LATENCY - 2);
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= RESPOND;
            ack_q <= 1'b1;
`ifdef MEMRESP_OOR_ERR_EN
            err_q <= req_oor;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESPOND: begin
          state  <= IDLE;
          ack_q  <= 1'b0;
          busy_q <= 1'b0;
`ifdef MEMRESP_OOR_ERR_EN
          err_q  <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_res.ack  = ack_q;
  assign mem_res.data = ram_rdata;
  assign busy         = busy_q;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Bench: three responders (LATENCY 4, 1, 7) checked against a line-storage model and latency rules.
module tb_cache_mem_responder;
  import cache_parameters::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  memory_request_t  req  [3];
  memory_response_t res  [3];
  logic             busy [3];
`ifdef MEMRESP_OOR_ERR_EN
  logic             err  [3];
`endif

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 4 : (g == 1) ? 1 : 7;
    cache_mem_responder #(.MEM_LINES(1024), .LATENCY(LAT)) u_dut (
      .clk     (clk),
      .rst     (rst),
      .mem_req (req[g]),
      .mem_res (res[g]),
`ifdef MEMRESP_OOR_ERR_EN
      .err     (err[g]),
`endif
      .busy    (busy[g])
    );
  end

  int    n_checks = 0;
  int    n_fail   = 0;
  line_t model [int];
  line_t last_rd [3];

  function automatic int lat_of(input int d);
    return (d == 0) ? 4 : (d == 1) ? 1 : 7;
  endfunction

  function automatic bit is_oor(input int unsigned idx);
`ifdef MEMRESP_OOR_ERR_EN
    return idx >= 1024;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int key_of(input int d, input int unsigned idx);
    return d * 4096 + int'(idx % 1024);
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; drives the request, follows it to its ack and one cycle past.
  task automatic xact(input int d, input bit rw, input int unsigned idx, input line_t wd,
                      input bit b2b, output int ack_cyc);
    bit    got, oor;
    int    lat, key;
    line_t exp;
    oor = is_oor(idx);
    key = key_of(d, idx);
    req[d].cs   = 1'b1;
    req[d].rw   = rw;
    req[d].addr = {idx[27:0], 4'($urandom)};
    req[d].data = wd;
    got = 0; lat = 0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      if (!b2b) req[d].cs = 1'b0;
      if (res[d].ack === 1'b1) begin
        got = 1; lat = c;
      end else begin
        chk("busy_wait", busy[d], 1);
`ifdef MEMRESP_OOR_ERR_EN
        chk("err_quiet", err[d], 0);
`endif
      end
    end
    ack_cyc = cyc;
    chk("ack_seen", got, 1);
    if (got) begin
      chk("latency", lat, lat_of(d));
      chk("busy_ack", busy[d], 1);
      if (rw) begin
        chk("wr_data_hold", res[d].data, last_rd[d]);
        if (!oor) model[key] = wd;
      end else begin
        exp = oor ? '0 : model[key];
        chk("rd_data", res[d].data, exp);
        last_rd[d] = exp;
      end
`ifdef MEMRESP_OOR_ERR_EN
      chk("err_ack", err[d], oor);
`endif
    end
    @(negedge clk);
    chk("ack_single", res[d].ack, 0);
    chk("busy_idle", busy[d], 0);
  endtask

  initial begin
    int    a0, a1;
    bit    rw;
    int    unsigned idx;
    int    gap;
    line_t x3;
    for (int d = 0; d < 3; d++) begin
      req[d] = '0;
      last_rd[d] = '0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_ack", res[d].ack, 0);
      chk("rst_busy", busy[d], 0);
      chk("rst_data", res[d].data, 0);
`ifdef MEMRESP_OOR_ERR_EN
      chk("rst_err", err[d], 0);
`endif
    end
    rst = 1'b0;
    @(negedge clk);

    // Line 5 = {A,B,C,D}, read back at LATENCY 4
    xact(0, 1, 5, {32'hA, 32'hB, 32'hC, 32'hD}, 0, a0);
    @(negedge clk);
    xact(0, 0, 5, '0, 0, a0);
    chk("line5", last_rd[0], {32'hA, 32'hB, 32'hC, 32'hD});

    // Write line 9 then read it with no idle cycle in between
    xact(0, 1, 9, {32'd1, 32'd2, 32'd3, 32'd4}, 1, a0);
    xact(0, 0, 9, '0, 0, a1);
    chk("line9", last_rd[0], {32'd1, 32'd2, 32'd3, 32'd4});
    chk("b2b_gap", a1 - a0, 5);

    // Write-back then allocate, cs held by the cache
    xact(0, 1, 20, {4{32'hC0FFEE00}}, 1, a0);
    xact(0, 0, 5, '0, 0, a1);
    chk("hold_gap", a1 - a0, 5);
    xact(0, 0, 20, '0, 0, a0);

    // LATENCY 1 and 7 instances
    xact(1, 1, 2, {4{32'h11111111}}, 1, a0);
    xact(1, 0, 2, '0, 0, a1);
    chk("l1_gap", a1 - a0, 2);
    xact(2, 1, 6, {4{32'h77777777}}, 1, a0);
    xact(2, 0, 6, '0, 0, a1);
    chk("l7_gap", a1 - a0, 8);

    // Reset two cycles into a write of line 3
    x3 = {32'h3, 32'h33, 32'h333, 32'h3333};
    xact(0, 1, 3, x3, 0, a0);
    req[0] = '{cs: 1'b1, rw: 1'b1, addr: 32'h30, data: {4{32'hDEADBEEF}}};
    @(negedge clk);
    req[0].cs = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_ack", res[0].ack, 0);
    chk("abort_busy", busy[0], 0);
    chk("abort_data", res[0].data, 0);
    for (int d = 0; d < 3; d++) last_rd[d] = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("abort_noack", res[0].ack, 0);
    end
    xact(0, 0, 3, '0, 0, a0);
    chk("line3_kept", last_rd[0], x3);

    // Index 1500 aliases line 476 unless flagged out of range
    xact(0, 1, 476, {4{32'h476}}, 0, a0);
    @(negedge clk);
    xact(0, 1, 1500, {4{32'h1500}}, 0, a0);
    @(negedge clk);
    xact(0, 0, 476, '0, 0, a0);
    @(negedge clk);
    xact(0, 0, 1500, '0, 0, a0);

    // Random traffic on every instance
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 25; i++) begin
        rw  = 1'($urandom_range(0, 1));
        idx = $urandom_range(0, 15);
        if ($urandom_range(0, 3) == 0) idx += 1024 * $urandom_range(1, 3);
        if (!rw && !is_oor(idx) && !model.exists(key_of(d, idx))) rw = 1'b1;
        gap = $urandom_range(0, 2);
        xact(d, rw, idx, {$urandom, $urandom, $urandom, $urandom}, gap == 0, a0);
        repeat (gap) @(negedge clk);
      end
      req[d].cs = 1'b0;
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
